// File: rtl/line_frame_gen_pkg.sv
// Shared types, widths and helpers for the synthetic line frame generator.
package line_gen_pkg;

  localparam int COL_W = 11;
  localparam int ROW_W = 9;
  localparam int POS_W = 13;
  localparam int PIX_W = 4;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HBLANK,
    VBLANK
  } state_t;

  // Width of a counter that must hold 0..div-1 (never narrower than one bit).
  function automatic int pace_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  // True when column col falls inside [left, left+width); left may be negative,
  // so everything is widened to a common signed width before comparing.
  function automatic logic pixel_lit(input logic [COL_W-1:0] col,
                                     input logic signed [POS_W-1:0] left,
                                     input logic [7:0] width);
    logic signed [POS_W+1:0] c;
    logic signed [POS_W+1:0] l;
    logic signed [POS_W+1:0] r;
    c = $signed({4'b0000, col});
    l = $signed({{2{left[POS_W-1]}}, left});
    r = l + $signed({7'b0000000, width});
    return (c >= l) && (c < r);
  endfunction

endpackage

// File: rtl/line_frame_gen_if.sv
// Pixel stream bus from the frame generator towards the centroid tracker.
interface line_frame_gen_if;
  import line_gen_pkg::*;

  logic pix_valid;
  pix_t pix_data;
  logic sof;
  logic eol;

  modport master (output pix_valid, pix_data, sof, eol);
  modport slave  (input  pix_valid, pix_data, sof, eol);
endinterface

// File: rtl/line_frame_gen_pix_pacer.sv
// Pixel strobe pacer: tick marks the last clock of each PIX_DIV-clock pixel slot.
module pix_pacer
  import line_gen_pkg::*;
#(
  parameter int PIX_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = pace_width(PIX_DIV);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(PIX_DIV - 1));

  // Count clocks within a pixel slot; restart aligns slot 0 with the first pixel of a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/line_frame_gen.sv
// Synthetic raster source: frames with one bright, skewable line on a flat background.
module line_frame_gen #(
  parameter int         IMG_W    = 640,
  parameter int         IMG_H    = 480,
  parameter int         HBLANK   = 16,
  parameter int         VBLANK   = 1000,
  parameter int         PIX_DIV  = 1,
  parameter logic [3:0] LINE_LVL = 4'd15,
  parameter logic [3:0] BG_LVL   = 4'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [10:0]      line_x,
  input  logic [7:0]       line_w,
  input  logic [3:0]       line_skew,
  line_frame_gen_if.master pix,
  output logic             frame_done,
  output logic             busy
);
  import line_gen_pkg::state_t;
  import line_gen_pkg::COL_W;
  import line_gen_pkg::ROW_W;
  import line_gen_pkg::POS_W;
  import line_gen_pkg::pixel_lit;

  localparam int BLK_W = 16;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  state_t                  state;
  logic [COL_W-1:0]        col;
  logic [ROW_W-1:0]        row;
  logic signed [POS_W-1:0] left;
  logic [7:0]              width;
  logic [3:0]              skew;
  logic [BLK_W-1:0]        blank_cnt;

  logic                    tick;
  logic                    row_start;
  logic                    last_col;
  logic                    last_row;
  logic                    hblank_done;
  logic                    vblank_done;
  logic [COL_W-1:0]        next_col;
  logic signed [POS_W-1:0] next_left;
  logic signed [POS_W-1:0] first_left;

  assign next_col    = col + COL_W'(1);
  assign next_left   = left + $signed({{(POS_W-4){skew[3]}}, skew});
  assign first_left  = $signed({2'b00, line_x});
  assign last_col    = (col == LAST_COL);
  assign last_row    = (row == LAST_ROW);
  assign hblank_done = (blank_cnt == BLK_W'(HBLANK - 1));
  assign vblank_done = (blank_cnt == BLK_W'(VBLANK - 1));

  // Every clock that emits column 0 of a row restarts the pixel slot timing.
  assign row_start = ((state == line_gen_pkg::IDLE)   && enable) ||
                     ((state == line_gen_pkg::HBLANK) && hblank_done) ||
                     ((state == line_gen_pkg::VBLANK) && vblank_done && enable) ||
                     ((state == line_gen_pkg::ACTIVE) && tick && last_col && !last_row &&
                      (HBLANK == 0));

  pix_pacer #(.PIX_DIV(PIX_DIV)) u_pacer (
    .clk     (clk),
    .rst     (rst),
    .restart (row_start),
    .tick    (tick)
  );

  // Frame sequencer; every output is registered on the edge that starts its pixel slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= line_gen_pkg::IDLE;
      col           <= '0;
      row           <= '0;
      left          <= '0;
      width         <= '0;
      skew          <= '0;
      blank_cnt     <= '0;
      pix.pix_valid <= 1'b0;
      pix.pix_data  <= '0;
      pix.sof       <= 1'b0;
      pix.eol       <= 1'b0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      pix.pix_valid <= 1'b0;
      pix.sof       <= 1'b0;
      pix.eol       <= 1'b0;
      frame_done    <= 1'b0;
      case (state)
        line_gen_pkg::IDLE: begin
          if (enable) begin
            width         <= line_w;
            skew          <= line_skew;
            left          <= first_left;
            col           <= '0;
            row           <= '0;
            state         <= line_gen_pkg::ACTIVE;
            busy          <= 1'b1;
            pix.pix_valid <= 1'b1;
            pix.sof       <= 1'b1;
            pix.eol       <= (LAST_COL == '0);
            pix.pix_data  <= pixel_lit('0, first_left, line_w) ? LINE_LVL : BG_LVL;
          end
        end
        line_gen_pkg::ACTIVE: begin
          if (tick) begin
            if (!last_col) begin
              col           <= next_col;
              pix.pix_valid <= 1'b1;
              pix.eol       <= (next_col == LAST_COL);
              pix.pix_data  <= pixel_lit(next_col, left, width) ? LINE_LVL : BG_LVL;
            end else begin
              col  <= '0;
              left <= next_left;
              if (!last_row) begin
                row <= row + ROW_W'(1);
                if (HBLANK == 0) begin
                  pix.pix_valid <= 1'b1;
                  pix.eol       <= (LAST_COL == '0);
                  pix.pix_data  <= pixel_lit('0, next_left, width) ? LINE_LVL : BG_LVL;
                end else begin
                  state     <= line_gen_pkg::HBLANK;
                  blank_cnt <= '0;
                end
              end else begin
                state      <= line_gen_pkg::VBLANK;
                blank_cnt  <= '0;
                frame_done <= 1'b1;
              end
            end
          end
        end
        line_gen_pkg::HBLANK: begin
          if (hblank_done) begin
            state         <= line_gen_pkg::ACTIVE;
            pix.pix_valid <= 1'b1;
            pix.eol       <= (LAST_COL == '0);
            pix.pix_data  <= pixel_lit('0, left, width) ? LINE_LVL : BG_LVL;
          end else begin
            blank_cnt <= blank_cnt + BLK_W'(1);
          end
        end
        line_gen_pkg::VBLANK: begin
          if (vblank_done) begin
            if (enable) begin
              width         <= line_w;
              skew          <= line_skew;
              left          <= first_left;
              col           <= '0;
              row           <= '0;
              state         <= line_gen_pkg::ACTIVE;
              pix.pix_valid <= 1'b1;
              pix.sof       <= 1'b1;
              pix.eol       <= (LAST_COL == '0);
              pix.pix_data  <= pixel_lit('0, first_left, line_w) ? LINE_LVL : BG_LVL;
            end else begin
              state <= line_gen_pkg::IDLE;
              busy  <= 1'b0;
            end
          end else begin
            blank_cnt <= blank_cnt + BLK_W'(1);
          end
        end
        default: begin
          state <= line_gen_pkg::IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_frame_gen.sv
// Self-checking bench: two generator instances (unpaced and PIX_DIV=3) against a timing model.
module tb_line_frame_gen;

  localparam int AW = 16, AH = 4, AHB = 3, AVB = 6, AD = 1;
  localparam int BW = 8,  BH = 2, BHB = 5, BVB = 4, BD = 3;
  localparam int A_FLEN = AH * (AW * AD + AHB) - AHB + AVB;
  localparam int B_FLEN = BH * (BW * BD + BHB) - BHB + BVB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [10:0] line_x = '0;
  logic [7:0]  line_w = '0;
  logic [3:0]  line_skew = '0;
  logic        frame_done_a, busy_a, frame_done_b, busy_b;

  int errors = 0;
  int checks = 0;

  line_frame_gen_if bus_a ();
  line_frame_gen_if bus_b ();

  line_frame_gen #(.IMG_W(AW), .IMG_H(AH), .HBLANK(AHB), .VBLANK(AVB), .PIX_DIV(AD),
                   .LINE_LVL(4'd15), .BG_LVL(4'd0)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .line_x(line_x), .line_w(line_w),
    .line_skew(line_skew), .pix(bus_a), .frame_done(frame_done_a), .busy(busy_a));

  line_frame_gen #(.IMG_W(BW), .IMG_H(BH), .HBLANK(BHB), .VBLANK(BVB), .PIX_DIV(BD),
                   .LINE_LVL(4'd15), .BG_LVL(4'd0)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .line_x(line_x), .line_w(line_w),
    .line_skew(line_skew), .pix(bus_b), .frame_done(frame_done_b), .busy(busy_b));

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected outputs t clocks after a frame's first strobe, from frame geometry alone.
  function automatic void model_out(input int w, h, d, hb, input int run, t, lx, lw, sk,
                                    output int v, data, sof, eol, done, bsy);
    int p, row, off, col, left;
    v = 0; data = 0; sof = 0; eol = 0; done = 0; bsy = run;
    if (run != 0) begin
      p = w * d + hb;
      if (t < h * p - hb) begin
        row = t / p;
        off = t % p;
        if (off < w * d && off % d == 0) begin
          col  = off / d;
          left = lx + row * sk;
          v    = 1;
          data = (col >= left && col < left + lw) ? 15 : 0;
          sof  = (row == 0 && col == 0) ? 1 : 0;
          eol  = (col == w - 1) ? 1 : 0;
        end
      end
      done = (t == h * p - hb) ? 1 : 0;
    end
  endfunction

  int ma_run = 0, ma_t = 0, ma_lx = 0, ma_lw = 0, ma_sk = 0;
  int mb_run = 0, mb_t = 0, mb_lx = 0, mb_lw = 0, mb_sk = 0;

  // Model of instance A: idle, or t clocks into a frame; config captured at frame start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma_run <= 0; ma_t <= 0;
    end else if (ma_run == 0 || ma_t == A_FLEN - 1) begin
      if (enable) begin
        ma_run <= 1; ma_t <= 0;
        ma_lx <= int'(line_x); ma_lw <= int'(line_w); ma_sk <= int'($signed(line_skew));
      end else begin
        ma_run <= 0;
      end
    end else begin
      ma_t <= ma_t + 1;
    end
  end

  // Model of instance B, same rules with its own frame length.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mb_run <= 0; mb_t <= 0;
    end else if (mb_run == 0 || mb_t == B_FLEN - 1) begin
      if (enable) begin
        mb_run <= 1; mb_t <= 0;
        mb_lx <= int'(line_x); mb_lw <= int'(line_w); mb_sk <= int'($signed(line_skew));
      end else begin
        mb_run <= 0;
      end
    end else begin
      mb_t <= mb_t + 1;
    end
  end

  int ev, ed, es, ee, edn, eb;

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    model_out(AW, AH, AD, AHB, ma_run, ma_t, ma_lx, ma_lw, ma_sk, ev, ed, es, ee, edn, eb);
    check_output("A pix_valid", int'(bus_a.pix_valid), ev);
    check_output("A sof", int'(bus_a.sof), es);
    check_output("A eol", int'(bus_a.eol), ee);
    check_output("A frame_done", int'(frame_done_a), edn);
    check_output("A busy", int'(busy_a), eb);
    if (ev != 0) check_output("A pix_data", int'(bus_a.pix_data), ed);
    model_out(BW, BH, BD, BHB, mb_run, mb_t, mb_lx, mb_lw, mb_sk, ev, ed, es, ee, edn, eb);
    check_output("B pix_valid", int'(bus_b.pix_valid), ev);
    check_output("B sof", int'(bus_b.sof), es);
    check_output("B eol", int'(bus_b.eol), ee);
    check_output("B frame_done", int'(frame_done_b), edn);
    check_output("B busy", int'(busy_b), eb);
    if (ev != 0) check_output("B pix_data", int'(bus_b.pix_data), ed);
  end

  logic [AW-1:0] cap_a [AH];
  int cap_row_a = AH, cap_col_a = 0, cnt_a = 0, last_cnt_a = 0, frames_a = 0;
  int cnt_b = 0, last_cnt_b = 0, eol_b = 0, last_eol_b = 0;

  // Rebuild A's lit mask per row and count strobes per frame from the observed streams.
  always @(negedge clk) begin
    if (bus_a.pix_valid) begin
      if (bus_a.sof) begin
        for (int r = 0; r < AH; r++) cap_a[r] = '0;
        cap_row_a = 0; cap_col_a = 0; cnt_a = 0;
      end
      if (cap_row_a < AH && cap_col_a < AW) cap_a[cap_row_a][cap_col_a] = (bus_a.pix_data == 4'd15);
      cnt_a++;
      cap_col_a++;
      if (bus_a.eol) begin
        cap_row_a++;
        cap_col_a = 0;
      end
    end
    if (frame_done_a) begin
      frames_a++;
      last_cnt_a = cnt_a;
    end
    if (bus_b.pix_valid) begin
      if (bus_b.sof) begin
        cnt_b = 0; eol_b = 0;
      end
      cnt_b++;
      if (bus_b.eol) eol_b++;
    end
    if (frame_done_b) begin
      last_cnt_b = cnt_b;
      last_eol_b = eol_b;
    end
  end

  function automatic bit cond(input int which);
    case (which)
      0:       return frame_done_a;
      1:       return !busy_a && !busy_b;
      2:       return bus_a.pix_valid;
      3:       return cap_row_a == 1;
      default: return cap_row_a == 2;
    endcase
  endfunction

  task automatic wait_for(input int which, input string name, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = cond(which);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("[TB] FAIL %s: timed out after %0d cycles", name, budget);
    end
  endtask

  task automatic apply_stimulus(input int lx, lw, sk, input bit en);
    @(posedge clk);
    #1;
    line_x    = 11'(lx);
    line_w    = 8'(lw);
    line_skew = 4'(sk);
    enable    = en;
  endtask

  task automatic run_frame(input int lx, lw, sk);
    apply_stimulus(lx, lw, sk, 1'b1);
    wait_for(0, "frame_done A", 300);
    apply_stimulus(lx, lw, sk, 1'b0);
    wait_for(1, "return to idle", 300);
  endtask

  int pv, pd, ps, pe, pdn, pb;

  initial begin
    // Pin the timing model on instance B geometry (row period 29 clocks).
    model_out(BW, BH, BD, BHB, 1, 3, 0, 0, 0, pv, pd, ps, pe, pdn, pb);
    check_output("model t3 strobe", pv, 1);
    model_out(BW, BH, BD, BHB, 1, 24, 0, 0, 0, pv, pd, ps, pe, pdn, pb);
    check_output("model t24 hblank", pv, 0);
    model_out(BW, BH, BD, BHB, 1, 50, 0, 0, 0, pv, pd, ps, pe, pdn, pb);
    check_output("model t50 eol", pe, 1);
    model_out(BW, BH, BD, BHB, 1, 53, 0, 0, 0, pv, pd, ps, pe, pdn, pb);
    check_output("model t53 done", pdn, 1);

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset pix_valid", int'(bus_a.pix_valid), 0);
    check_output("reset busy A", int'(busy_a), 0);
    check_output("reset busy B", int'(busy_b), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_frame(5, 3, 0);
    check_output("basic row0", int'(cap_a[0]), 16'h00E0);
    check_output("basic row3", int'(cap_a[3]), 16'h00E0);
    check_output("strobes A", last_cnt_a, AW * AH);
    check_output("strobes B", last_cnt_b, 16);
    check_output("eol count B", last_eol_b, 2);

    run_frame(12, 8, 0);
    check_output("clip row0", int'(cap_a[0]), 16'hF000);
    check_output("clip row2 col0", int'(cap_a[2][0]), 0);

    run_frame(4, 4, -8);
    check_output("skew-8 row0", int'(cap_a[0]), 16'h00F0);
    check_output("skew-8 row1", int'(cap_a[1]), 0);

    run_frame(1, 2, 3);
    check_output("skew+3 row0", int'(cap_a[0]), 16'h0006);
    check_output("skew+3 row1", int'(cap_a[1]), 16'h0030);
    check_output("skew+3 row2", int'(cap_a[2]), 16'h0180);
    check_output("skew+3 row3", int'(cap_a[3]), 16'h0C00);

    run_frame(5, 0, 0);
    for (int r = 0; r < AH; r++) check_output("empty row", int'(cap_a[r]), 0);
    check_output("frames A", frames_a, 5);

    apply_stimulus(2, 2, 0, 1'b1);
    wait_for(3, "midframe row1", 100);
    apply_stimulus(9, 2, 0, 1'b0);
    wait_for(0, "midframe frame_done", 200);
    check_output("midframe row0", int'(cap_a[0]), 16'h000C);
    check_output("midframe row3", int'(cap_a[3]), 16'h000C);
    wait_for(1, "midframe idle", 100);
    check_output("midframe busy", int'(busy_a), 0);

    apply_stimulus(5, 3, 0, 1'b1);
    wait_for(4, "reset at row2", 100);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_output("abort pix_valid", int'(bus_a.pix_valid), 0);
    check_output("abort busy", int'(busy_a), 0);
    @(negedge clk);
    check_output("abort held busy", int'(busy_a), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_for(2, "restart strobe", 20);
    check_output("restart sof", int'(bus_a.sof), 1);
    check_output("restart data", int'(bus_a.pix_data), 0);
    apply_stimulus(5, 3, 0, 1'b0);
    wait_for(1, "final idle", 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
